bkram_sequencer: RTL and testbench

//  Sequences backup-RAM (cartridge save) transfers between the 32 KiB nvram dpram and the

---
 rtl/bkram_pkg.sv | 13 +
 rtl/bkram_sequencer.sv | 162 ++++++++++++++++
 tb/tb_bkram_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bkram_pkg.sv
// Shared constants for the backup-RAM sequencer: FSM state codes, sector size, ack timeout.
package bkram_pkg;

  typedef logic [1:0] bk_state_t;

  localparam bk_state_t ST_IDLE = 2'd0;
  localparam bk_state_t ST_REQ  = 2'd1;
  localparam bk_state_t ST_XFER = 2'd2;

  localparam int          SECT_BYTES = 512;
  localparam logic [23:0] BK_ACK_TMO = 24'hFFFFFF;

endpackage

// File: rtl/bkram_sequencer.sv
// Backup-RAM save sequencer: streams the nvram image sector by sector to/from the mounted save file.
// Request rises 1 cycle after an accepted edge; one sector in flight; edges seen while busy are dropped.
module bkram_sequencer
  import bkram_pkg::*;
#(
  parameter int          SECT_LOG2 = 6,
  parameter logic [23:0] ACK_TMO   = BK_ACK_TMO
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        bk_ena,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        autoload,
  input  logic        autosave_en,
  input  logic        osd_status,
  input  logic        nvram_we,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        busy,
  output logic        loading,
  output logic        dirty,
  output logic        error
);

  bk_state_t            r_state;
  logic [23:0]          r_cnt;
  logic [SECT_LOG2-1:0] r_lba;
  logic                 r_rd;
  logic                 r_wr;
  logic                 r_busy;
  logic                 r_loading;
  logic                 r_dirty;
  logic                 r_error;
  logic                 r_load_d;
  logic                 r_save_d;
  logic                 r_osd_d;
  logic                 r_ack_d;

  logic w_load_lvl;
  logic w_save_lvl;
  logic w_load_edge;
  logic w_save_edge;
  logic w_autoload;
  logic w_autosave;
  logic w_start_load;
  logic w_start_save;
  logic w_idle;
  logic w_ack_rise;
  logic w_ack_fall;
  logic w_last;
  logic w_tmo;
  logic w_save_start;
  logic w_load_done;

  assign w_load_lvl  = load_req & bk_ena;
  assign w_save_lvl  = save_req & bk_ena;
  assign w_load_edge = w_load_lvl & ~r_load_d;
  assign w_save_edge = w_save_lvl & ~r_save_d;
  assign w_autoload  = autoload & bk_ena;
  // Autosave fires on OSD close, and only when there is something new to write.
  assign w_autosave  = ~osd_status & r_osd_d & autosave_en & bk_ena & r_dirty;

  assign w_start_load = w_load_edge | w_autoload;
  assign w_start_save = ~w_start_load & (w_save_edge | w_autosave);

  assign w_idle     = (r_state == ST_IDLE);
  assign w_ack_rise = sd_ack & ~r_ack_d;
  assign w_ack_fall = ~sd_ack & r_ack_d;
  assign w_last     = &r_lba;
  assign w_tmo      = (r_cnt == ACK_TMO - 24'd1);

  assign w_save_start = w_idle & w_start_save;
  assign w_load_done  = (r_state == ST_XFER) & w_ack_fall & w_last & r_loading;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_lba     <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_busy    <= 1'b0;
      r_loading <= 1'b0;
      r_dirty   <= 1'b0;
      r_error   <= 1'b0;
      // Preload edge history so levels already high at release do not count as edges.
      r_load_d  <= w_load_lvl;
      r_save_d  <= w_save_lvl;
      r_osd_d   <= osd_status;
      r_ack_d   <= sd_ack;
    end else begin
      r_load_d <= w_load_lvl;
      r_save_d <= w_save_lvl;
      r_osd_d  <= osd_status;
      r_ack_d  <= sd_ack;

      // A core write racing the start of a save must survive: the save may miss it.
      r_dirty <= nvram_we | (r_dirty & ~w_save_start & ~w_load_done);

      case (r_state)
        ST_IDLE: begin
          if (w_start_load | w_start_save) begin
            r_lba     <= '0;
            r_rd      <= w_start_load;
            r_wr      <= ~w_start_load;
            r_busy    <= 1'b1;
            r_loading <= w_start_load;
            r_error   <= 1'b0;
            r_cnt     <= '0;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_ack_rise) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_XFER;
          end else if (w_tmo) begin
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_error   <= 1'b1;
            r_busy    <= 1'b0;
            r_loading <= 1'b0;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        ST_XFER: begin
          if (w_ack_fall) begin
            if (w_last) begin
              r_busy    <= 1'b0;
              r_loading <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              r_lba   <= r_lba + SECT_LOG2'(1);
              r_rd    <= r_loading;
              r_wr    <= ~r_loading;
              r_cnt   <= '0;
              r_state <= ST_REQ;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sd_lba  = {{(32-SECT_LOG2){1'b0}}, r_lba};
  assign sd_rd   = r_rd;
  assign sd_wr   = r_wr;
  assign busy    = r_busy;
  assign loading = r_loading;
  assign dirty   = r_dirty;
  assign error   = r_error;

endmodule

// File: tb/tb_bkram_sequencer.sv
// Bench for bkram_sequencer: random hps_io ack responder, transaction-level model checked every cycle.
module tb_bkram_sequencer;

  localparam int TMO   = 100;
  localparam int NSECT = 64;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        bk_ena = 1'b0;
  logic        load_req = 1'b0;
  logic        save_req = 1'b0;
  logic        autoload = 1'b0;
  logic        autosave_en = 1'b0;
  logic        osd_status = 1'b0;
  logic        nvram_we = 1'b0;
  logic        sd_ack = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        busy;
  logic        loading;
  logic        dirty;
  logic        error;

  bkram_sequencer #(.SECT_LOG2(6), .ACK_TMO(24'd100)) dut (
    .clk_sys(clk_sys), .reset(reset), .bk_ena(bk_ena), .load_req(load_req),
    .save_req(save_req), .autoload(autoload), .autosave_en(autosave_en),
    .osd_status(osd_status), .nvram_we(nvram_we), .sd_ack(sd_ack),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .busy(busy),
    .loading(loading), .dirty(dirty), .error(error)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // hps_io-like responder: after seeing a request, ack rises after a random delay, holds, falls.
  int ack_phase = 0;
  int ack_cnt   = 0;
  int ack_dly   = 0;
  int ack_hold  = 0;
  int hold_lo   = 1;
  int hold_hi   = 4;
  bit ack_en    = 1'b1;

  always @(posedge clk_sys) begin
    #1;
    case (ack_phase)
      0: if (ack_en && (sd_rd || sd_wr)) begin
        ack_dly   = $urandom_range(1, 30);
        ack_cnt   = 0;
        ack_phase = 1;
      end
      1: begin
        ack_cnt++;
        if (ack_cnt >= ack_dly) begin
          sd_ack    = 1'b1;
          ack_hold  = $urandom_range(hold_lo, hold_hi);
          ack_cnt   = 0;
          ack_phase = 2;
        end
      end
      2: begin
        ack_cnt++;
        if (ack_cnt >= ack_hold) begin
          sd_ack    = 1'b0;
          ack_phase = 3;
        end
      end
      default: ack_phase = 0;
    endcase
  end

  // Transaction-level reference: a transfer is 64 sectors, each "waiting for ack" then "in flight".
  bit m_active = 0, m_load = 0, m_wait = 0;
  int m_sect = 0, m_waited = 0;
  bit e_dirty = 0, e_error = 0;
  bit p_ld = 0, p_sv = 0, p_osd = 0, p_ack = 0;

  always @(posedge clk_sys) begin : model
    bit ld_e, sv_e, as_e, go_ld, go_sv, done_ld;
    if (reset) begin
      m_active = 0; m_load = 0; m_wait = 0; m_sect = 0; m_waited = 0;
      e_dirty = 0; e_error = 0;
    end else begin
      ld_e = load_req && bk_ena && !p_ld;
      sv_e = save_req && bk_ena && !p_sv;
      as_e = !osd_status && p_osd && autosave_en && bk_ena && e_dirty;
      go_ld = 0; go_sv = 0; done_ld = 0;
      if (!m_active) begin
        if (ld_e || (autoload && bk_ena)) go_ld = 1;
        else if (sv_e || as_e) go_sv = 1;
        if (go_ld || go_sv) begin
          m_active = 1; m_load = go_ld; m_wait = 1; m_waited = 0; m_sect = 0; e_error = 0;
        end
      end else if (m_wait) begin
        if (sd_ack && !p_ack) m_wait = 0;
        else begin
          m_waited++;
          if (m_waited == TMO) begin
            m_active = 0; e_error = 1;
          end
        end
      end else if (!sd_ack && p_ack) begin
        if (m_sect == NSECT - 1) begin
          m_active = 0; done_ld = m_load;
        end else begin
          m_sect++; m_wait = 1; m_waited = 0;
        end
      end
      e_dirty = nvram_we || (e_dirty && !go_sv && !done_ld);
    end
    p_ld = load_req && bk_ena; p_sv = save_req && bk_ena; p_osd = osd_status; p_ack = sd_ack;
  end

  bit cmp_en = 0;
  always @(negedge clk_sys) begin
    if (cmp_en) begin
      check("cyc_lba", sd_lba, m_sect);
      check("cyc_rd", sd_rd, m_active && m_wait && m_load);
      check("cyc_wr", sd_wr, m_active && m_wait && !m_load);
      check("cyc_busy", busy, m_active);
      check("cyc_loading", loading, m_active && m_load);
      check("cyc_dirty", dirty, e_dirty);
      check("cyc_error", error, e_error);
    end
  end

  // Activity counters for the directed literal expectations.
  int rd_pulses = 0, wr_pulses = 0, rd_high = 0, loading_cyc = 0, max_lba = 0;
  bit prev_rd = 0, prev_wr = 0;
  always @(negedge clk_sys) begin
    if (sd_rd && !prev_rd) rd_pulses++;
    if (sd_wr && !prev_wr) wr_pulses++;
    if (sd_rd) rd_high++;
    if (loading) loading_cyc++;
    if ((sd_rd || sd_wr) && int'(sd_lba) > max_lba) max_lba = int'(sd_lba);
    prev_rd = sd_rd;
    prev_wr = sd_wr;
  end

  task automatic clear_mon();
    rd_pulses = 0; wr_pulses = 0; rd_high = 0; loading_cyc = 0; max_lba = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic pulse_we();
    nvram_we = 1'b1;
    tick(1);
    nvram_we = 1'b0;
  endtask

  initial begin
    int n;
    tick(1);
    cmp_en = 1;
    tick(2);
    reset = 1'b0;
    bk_ena = 1'b1;
    tick(1);
    check("rst_lba", sd_lba, 0);
    check("rst_busy", busy, 0);
    check("rst_dirty", dirty, 0);
    check("rst_error", error, 0);

    // Manual save of a dirty image.
    pulse_we();
    check("t1_dirty_set", dirty, 1);
    clear_mon();
    save_req = 1'b1;
    tick(1);
    check("t1_wr_start", sd_wr, 1);
    wait_idle("t1_done", 5000);
    check("t1_wr_pulses", wr_pulses, 64);
    check("t1_rd_pulses", rd_pulses, 0);
    check("t1_max_lba", max_lba, 63);
    check("t1_loading_cyc", loading_cyc, 0);
    check("t1_dirty", dirty, 0);
    save_req = 1'b0;
    tick(2);

    // Autoload after download.
    pulse_we();
    clear_mon();
    autoload = 1'b1;
    tick(1);
    autoload = 1'b0;
    check("t2_loading", loading, 1);
    check("t2_rd_start", sd_rd, 1);
    wait_idle("t2_done", 5000);
    check("t2_rd_pulses", rd_pulses, 64);
    check("t2_wr_pulses", wr_pulses, 0);
    check("t2_dirty", dirty, 0);
    check("t2_loading_end", loading, 0);

    // Autosave on OSD close, enabled then disabled.
    pulse_we();
    autosave_en = 1'b1;
    osd_status = 1'b1;
    tick(1);
    clear_mon();
    osd_status = 1'b0;
    tick(1);
    check("t3_wr_start", sd_wr, 1);
    wait_idle("t3_done", 5000);
    check("t3_wr_pulses", wr_pulses, 64);
    check("t3_dirty", dirty, 0);
    autosave_en = 1'b0;
    pulse_we();
    osd_status = 1'b1;
    tick(1);
    clear_mon();
    osd_status = 1'b0;
    tick(200);
    check("t3_off_wr", wr_pulses, 0);
    check("t3_off_dirty", dirty, 1);
    check("t3_off_busy", busy, 0);

    // Simultaneous load and save edges; save edge during load.
    clear_mon();
    load_req = 1'b1;
    save_req = 1'b1;
    tick(1);
    check("t4_rd", sd_rd, 1);
    check("t4_wr", sd_wr, 0);
    save_req = 1'b0;
    tick(50);
    save_req = 1'b1;
    wait_idle("t4_done", 5000);
    check("t4_rd_pulses", rd_pulses, 64);
    check("t4_wr_pulses", wr_pulses, 0);
    check("t4_dirty", dirty, 0);
    load_req = 1'b0;
    save_req = 1'b0;
    tick(2);

    // Ack timeout, then recovery.
    ack_en = 1'b0;
    clear_mon();
    load_req = 1'b1;
    tick(1);
    wait_idle("t5_abort", 400);
    check("t5_rd_high", rd_high, TMO);
    check("t5_rd_pulses", rd_pulses, 1);
    check("t5_error", error, 1);
    check("t5_loading", loading, 0);
    ack_en = 1'b1;
    load_req = 1'b0;
    tick(1);
    load_req = 1'b1;
    tick(1);
    check("t5_error_clr", error, 0);
    check("t5_busy", busy, 1);
    wait_idle("t5_done", 5000);
    load_req = 1'b0;
    tick(2);

    // Reset in the middle of a load, with a stray ack fall and save_req held across reset.
    hold_lo = 6;
    hold_hi = 6;
    clear_mon();
    load_req = 1'b1;
    tick(1);
    save_req = 1'b1;
    n = 0;
    while (!(sd_lba == 32'd17 && sd_ack) && n < 3000) begin
      tick(1);
      n++;
    end
    check("t6_reach_17", (sd_lba == 32'd17 && sd_ack) ? 1 : 0, 1);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t6_lba", sd_lba, 0);
    check("t6_rd", sd_rd, 0);
    check("t6_wr", sd_wr, 0);
    check("t6_busy", busy, 0);
    check("t6_loading", loading, 0);
    check("t6_dirty", dirty, 0);
    clear_mon();
    tick(300);
    check("t6_no_wr", wr_pulses, 0);
    check("t6_no_rd", rd_pulses, 0);
    check("t6_idle", busy, 0);
    hold_lo = 1;
    hold_hi = 4;
    load_req = 1'b0;
    save_req = 1'b0;
    tick(2);

    // Random traffic, every cycle checked against the model.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 299) == 0) bk_ena = ~bk_ena;
      if ($urandom_range(0, 399) == 0) load_req = ~load_req;
      if ($urandom_range(0, 399) == 0) save_req = ~save_req;
      if ($urandom_range(0, 499) == 0) autosave_en = ~autosave_en;
      if ($urandom_range(0, 199) == 0) osd_status = ~osd_status;
      if ($urandom_range(0, 1499) == 0) ack_en = ~ack_en;
      autoload = ($urandom_range(0, 1999) == 0);
      nvram_we = ($urandom_range(0, 19) == 0);
      reset    = ($urandom_range(0, 4999) == 0);
      tick(1);
    end
    reset = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
